// File: rtl/map_scan_if.sv
// Map-scan bundle: scan control, map RAM read port, classifier stream and
// the latched start/goal/wall results.
interface map_scan_if #(
  parameter int ADDR_W = 8
);
  logic              scan_req;
  logic              scan_abort;
  logic              scan_busy;
  logic              scan_done;
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_rdata;
  logic [7:0]        map_block;
  logic [ADDR_W-1:0] now;
  logic              in_do;
  logic [ADDR_W-1:0] start_pos;
  logic [ADDR_W-1:0] goal_pos;
  logic              start_found;
  logic              goal_found;
  logic              err_dup;
  logic [ADDR_W:0]   wall_cnt;

  // Controller / RAM side: issues requests, supplies RAM data, observes results.
  modport master (
    output scan_req, scan_abort, mem_rdata,
    input  scan_busy, scan_done, mem_rd, mem_addr, map_block, now, in_do,
           start_pos, goal_pos, start_found, goal_found, err_dup, wall_cnt
  );

  // Scanner side.
  modport slave (
    input  scan_req, scan_abort, mem_rdata,
    output scan_busy, scan_done, mem_rd, mem_addr, map_block, now, in_do,
           start_pos, goal_pos, start_found, goal_found, err_dup, wall_cnt
  );
endinterface

// File: rtl/map_scan.sv
// map_scan: streams every map cell from map RAM to the search-cell classifier,
// one cell per clock, while latching the first start/goal positions, flagging
// duplicates and counting wall cells (bit7 set).
module map_scan #(
  parameter int         ADDR_W     = 8,
  parameter int         MAP_SIZE   = 256,
  parameter logic [7:0] START_CODE = 8'h7F,
  parameter logic [7:0] GOAL_CODE  = 8'h00
) (
  input  logic     m_clock,
  input  logic     p_reset,
  map_scan_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MAP_SIZE - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W:0]   WALL_ONE  = (ADDR_W + 1)'(1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic              w_accept;
  logic              w_scan;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [ADDR_W-1:0] r_now_p1;
  logic              r_in_do_p1;
  logic [7:0]        w_cell;
  logic [ADDR_W-1:0] r_start_pos;
  logic [ADDR_W-1:0] r_goal_pos;
  logic              r_start_found;
  logic              r_goal_found;
  logic              r_err_dup;
  logic [ADDR_W:0]   r_wall_cnt;

  assign w_scan = (r_state == ST_SCAN);
  assign w_cell = bus.mem_rdata;

  // State register.
  always_ff @(posedge m_clock or negedge p_reset) begin
    if (!p_reset) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state logic; a request in IDLE wins over a simultaneous abort,
  // and abort is only honoured while the RAM stream is in flight.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.scan_req) begin
          w_state_nxt = ST_SCAN;
          w_accept    = 1'b1;
        end
      end
      ST_SCAN: begin
        if (bus.scan_abort)              w_state_nxt = ST_IDLE;
        else if (r_mem_addr == LAST_ADDR) w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (bus.scan_abort) w_state_nxt = ST_IDLE;
        else                w_state_nxt = ST_DONE;
      end
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Read address counter: cleared on an accepted request, steps once per SCAN cycle.
  always_ff @(posedge m_clock or negedge p_reset) begin
    if (!p_reset)                            r_mem_addr <= '0;
    else if (w_accept)                       r_mem_addr <= '0;
    else if (w_scan && r_mem_addr != LAST_ADDR) r_mem_addr <= r_mem_addr + ADDR_ONE;
  end

  // ---- stage p1: RAM data returns; read strobe and address delayed to match ----
  // Abort kills the in-flight valid on the same edge that returns to IDLE.
  always_ff @(posedge m_clock or negedge p_reset) begin
    if (!p_reset) begin
      r_in_do_p1 <= 1'b0;
      r_now_p1   <= '0;
    end else begin
      r_in_do_p1 <= w_scan && !bus.scan_abort;
      if (w_scan) r_now_p1 <= r_mem_addr;
    end
  end

  // Classification of each valid cell; first start/goal kept, repeats flag err_dup.
  always_ff @(posedge m_clock or negedge p_reset) begin
    if (!p_reset) begin
      r_start_pos   <= '0;
      r_goal_pos    <= '0;
      r_start_found <= 1'b0;
      r_goal_found  <= 1'b0;
      r_err_dup     <= 1'b0;
      r_wall_cnt    <= '0;
    end else if (w_accept) begin
      r_start_pos   <= '0;
      r_goal_pos    <= '0;
      r_start_found <= 1'b0;
      r_goal_found  <= 1'b0;
      r_err_dup     <= 1'b0;
      r_wall_cnt    <= '0;
    end else if (r_in_do_p1) begin
      if (w_cell == START_CODE) begin
        if (!r_start_found) begin
          r_start_pos   <= r_now_p1;
          r_start_found <= 1'b1;
        end else begin
          r_err_dup <= 1'b1;
        end
      end
      if (w_cell == GOAL_CODE) begin
        if (!r_goal_found) begin
          r_goal_pos   <= r_now_p1;
          r_goal_found <= 1'b1;
        end else begin
          r_err_dup <= 1'b1;
        end
      end
      if (w_cell[7]) r_wall_cnt <= r_wall_cnt + WALL_ONE;
    end
  end

  assign bus.scan_busy   = (r_state != ST_IDLE);
  assign bus.scan_done   = (r_state == ST_DONE);
  assign bus.mem_rd      = w_scan;
  assign bus.mem_addr    = r_mem_addr;
  assign bus.map_block   = w_cell;
  assign bus.now         = r_now_p1;
  assign bus.in_do       = r_in_do_p1;
  assign bus.start_pos   = r_start_pos;
  assign bus.goal_pos    = r_goal_pos;
  assign bus.start_found = r_start_found;
  assign bus.goal_found  = r_goal_found;
  assign bus.err_dup     = r_err_dup;
  assign bus.wall_cnt    = r_wall_cnt;

endmodule

// File: tb/tb_map_scan.sv
// Testbench for map_scan: RAM model, scoreboard of expected cell stream and
// per-scan results, randomized and directed maps.
module tb_map_scan;
  localparam int AW = 8;
  localparam int MS = 256;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  map_scan_if #(.ADDR_W(AW)) bus ();

  map_scan #(
    .ADDR_W(AW), .MAP_SIZE(MS), .START_CODE(8'h7F), .GOAL_CODE(8'h00)
  ) dut (
    .m_clock(clk),
    .p_reset(rst_n),
    .bus    (bus)
  );

  typedef struct {
    logic [AW-1:0] sp;
    logic [AW-1:0] gp;
    logic          sf;
    logic          gf;
    logic          dup;
    logic [AW:0]   wc;
    int            done_cyc;
  } res_t;

  logic [7:0] map_mem [MS];
  res_t res_q[$];
  int   exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   seen  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Map RAM: data valid one cycle after the read strobe.
  always @(posedge clk) if (bus.mem_rd) bus.mem_rdata <= map_mem[bus.mem_addr];

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference results straight from the map contents.
  function automatic res_t model(input int done_cyc);
    res_t r;
    int ns = 0, ng = 0, nw = 0;
    r.sp = '0; r.gp = '0;
    for (int i = 0; i < MS; i++) begin
      if (map_mem[i] == 8'h7F) begin if (ns == 0) r.sp = AW'(i); ns++; end
      if (map_mem[i] == 8'h00) begin if (ng == 0) r.gp = AW'(i); ng++; end
      if (map_mem[i][7]) nw++;
    end
    r.sf = (ns > 0); r.gf = (ng > 0); r.dup = (ns > 1) || (ng > 1);
    r.wc = (AW + 1)'(nw);
    r.done_cyc = done_cyc;
    return r;
  endfunction

  function automatic int walls_first(input int n);
    int w = 0;
    for (int i = 0; i < n && i < MS; i++) if (map_mem[i][7]) w++;
    return w;
  endfunction

  task automatic push_scan(input int done_cyc);
    for (int i = 0; i < MS; i++) exp_q.push_back(i);
    res_q.push_back(model(done_cyc));
  endtask

  // Monitor: pops expected cells on in_do and expected results on scan_done.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.in_do) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_in_do: got now=%0d expected no cell", bus.now);
        end else begin
          int idx;
          idx = exp_q.pop_front();
          chk("now", bus.now, idx);
          chk("map_block", bus.map_block, map_mem[idx]);
          seen++;
        end
      end
      if (bus.scan_done) begin
        if (res_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_done: got scan_done=1 expected 0 at cyc %0d", cyc);
        end else begin
          res_t e;
          e = res_q.pop_front();
          chk("done_latency", cyc, e.done_cyc);
          chk("start_pos", bus.start_pos, e.sp);
          chk("goal_pos", bus.goal_pos, e.gp);
          chk("start_found", bus.start_found, e.sf);
          chk("goal_found", bus.goal_found, e.gf);
          chk("err_dup", bus.err_dup, e.dup);
          chk("wall_cnt", bus.wall_cnt, e.wc);
          chk("in_do_count", seen, MS);
          chk("busy_in_done", bus.scan_busy, 1);
          seen = 0;
        end
      end
    end
  end

  task automatic check_zero(input string tag);
    chk({tag, "_mem_rd"}, bus.mem_rd, 0);
    chk({tag, "_mem_addr"}, bus.mem_addr, 0);
    chk({tag, "_now"}, bus.now, 0);
    chk({tag, "_in_do"}, bus.in_do, 0);
    chk({tag, "_busy"}, bus.scan_busy, 0);
    chk({tag, "_done"}, bus.scan_done, 0);
    chk({tag, "_start_pos"}, bus.start_pos, 0);
    chk({tag, "_goal_pos"}, bus.goal_pos, 0);
    chk({tag, "_start_found"}, bus.start_found, 0);
    chk({tag, "_goal_found"}, bus.goal_found, 0);
    chk({tag, "_err_dup"}, bus.err_dup, 0);
    chk({tag, "_wall_cnt"}, bus.wall_cnt, 0);
  endtask

  // Called #1 after a rising edge; the following edge samples the request.
  task automatic start_scan(input bit hold);
    seen = 0;
    push_scan(cyc + MS + 2);
    bus.scan_req = 1'b1;
    if (!hold) begin
      @(posedge clk); #1;
      bus.scan_req = 1'b0;
    end
  endtask

  task automatic wait_done(input string name);
    int t = 0;
    while (res_q.size() > 0 && t < 700) begin @(posedge clk); t++; end
    chk({name, "_timeout_pending"}, res_q.size(), 0);
    if (res_q.size() > 0) begin res_q.delete(); exp_q.delete(); end
    @(posedge clk); #1;
  endtask

  task automatic fill_rand(input bit no_goal);
    for (int i = 0; i < MS; i++) begin
      map_mem[i] = 8'($urandom_range(0, 255));
      if (no_goal && map_mem[i] == 8'h00) map_mem[i] = 8'h01;
    end
  endtask

  initial begin
    bus.scan_req   = 1'b0;
    bus.scan_abort = 1'b0;
    for (int i = 0; i < MS; i++) map_mem[i] = 8'h80;
    #2 rst_n = 1'b0;
    #1 check_zero("reset");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check_zero("idle");

    // 1: single start and goal in a wall map
    for (int i = 0; i < MS; i++) map_mem[i] = 8'h80;
    map_mem[5] = 8'h7F; map_mem[200] = 8'h00;
    start_scan(0);
    wait_done("t1");

    // 2: duplicate start; a request mid-scan must be ignored
    for (int i = 0; i < MS; i++) map_mem[i] = 8'h41;
    map_mem[3] = 8'h7F; map_mem[9] = 8'h7F; map_mem[77] = 8'h00;
    for (int i = 130; i < 140; i++) map_mem[i] = 8'hC3;
    start_scan(0);
    repeat (20) @(posedge clk);
    #1 bus.scan_req = 1'b1;
    @(posedge clk); #1 bus.scan_req = 1'b0;
    wait_done("t2");
    repeat (3) @(posedge clk);
    #1 chk("busy_req_ignored", bus.scan_busy, 0);

    // 3: no goal cell
    fill_rand(1'b1);
    start_scan(0);
    wait_done("t3");

    // 4: abort 50 cycles after the request, then a full scan
    for (int i = 0; i < MS; i++) map_mem[i] = (i % 3 == 0) ? 8'hF0 : 8'h22;
    map_mem[10] = 8'h7F; map_mem[20] = 8'h00;
    start_scan(0);
    repeat (49) @(posedge clk);
    #1 bus.scan_abort = 1'b1;
    @(posedge clk); #1 bus.scan_abort = 1'b0;
    chk("abort_busy", bus.scan_busy, 0);
    chk("abort_mem_rd", bus.mem_rd, 0);
    chk("abort_in_do", bus.in_do, 0);
    chk("abort_cells_seen", (seen > 0) ? 1 : 0, 1);
    chk("abort_partial_walls", bus.wall_cnt, walls_first(seen));
    chk("abort_partial_start", bus.start_found, (seen > 10) ? 1 : 0);
    exp_q.delete(); res_q.delete();
    repeat (5) @(posedge clk);
    #1 chk("abort_no_done_busy", bus.scan_busy, 0);
    fill_rand(1'b0);
    start_scan(0);
    chk("restart_wall_clear", bus.wall_cnt, 0);
    chk("restart_start_clear", bus.start_found, 0);
    wait_done("t4");

    // 5: request held high -> back-to-back scans with one IDLE cycle
    fill_rand(1'b0);
    begin
      int r0;
      r0 = cyc;
      start_scan(1);
      push_scan(r0 + 2 * MS + 5);
    end
    begin
      int t = 0;
      while (res_q.size() > 1 && t < 700) begin @(posedge clk); t++; end
    end
    @(posedge clk); #1 bus.scan_req = 1'b0;
    wait_done("t5");

    // 6: reset in mid-scan at cell 100, then a clean scan
    fill_rand(1'b0);
    start_scan(0);
    begin
      int t = 0;
      do begin @(negedge clk); t++; end
      while (!(bus.in_do && bus.now == 8'd100) && t < 400);
      chk("midrst_reached_cell100", bus.now, 100);
    end
    #2 rst_n = 1'b0;
    #1 check_zero("midrst");
    exp_q.delete(); res_q.delete(); seen = 0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    start_scan(0);
    wait_done("t6");

    // request together with abort in IDLE: the request wins
    fill_rand(1'b0);
    bus.scan_abort = 1'b1;
    start_scan(0);
    bus.scan_abort = 1'b0;
    wait_done("req_abort");

    // randomized scans
    for (int n = 0; n < 3; n++) begin
      fill_rand(1'b0);
      if ($urandom_range(0, 1) == 1) map_mem[$urandom_range(0, MS - 1)] = 8'h7F;
      start_scan(0);
      wait_done("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
